// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
// Shared definitions for the ALU and the two-requester ALU arbiter:
//   - ALU op-code width and the ALU_* op-code constants
//   - response-buffer state encoding (EMPTY=0, FULL=1)
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SL  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SR  = 3'd5;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd6;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd7;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational 32-bit integer ALU.
// Ports:
//   src1, src2 : operands (XLEN)
//   ctrl       : ALU_* op code
//   arith      : sign-filling right shift for ALU_SR
//   result     : operation result (XLEN)
//   zero       : result == 0
// ---------------------------------------------------------------------------
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]     src1,
  input  logic [XLEN-1:0]     src2,
  input  logic [ALU_OP_W-1:0] ctrl,
  input  logic                arith,
  output logic [XLEN-1:0]     result,
  output logic                zero
);

  logic signed [XLEN-1:0] src1_s;
  logic        [XLEN-1:0] diff;
  logic        [4:0]      shamt;

  assign src1_s = src1;
  assign diff   = src1 - src2;
  assign shamt  = src2[4:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = src1 + src2;
      ALU_SUB: result = diff;
      ALU_SL:  result = src1 << shamt;
      // Sign bit of the raw difference, not an overflow-corrected compare.
      ALU_SLT: result = {{(XLEN-1){1'b0}}, diff[XLEN-1]};
      ALU_XOR: result = src1 ^ src2;
      ALU_SR:  result = arith ? $unsigned(src1_s >>> shamt) : (src1 >> shamt);
      ALU_OR:  result = src1 | src2;
      ALU_AND: result = src1 & src2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two valid/ready requesters with round-robin grant.
// The granted operation's result is registered into a one-entry response
// buffer that drains through its own valid/ready handshake (latency 1,
// throughput 1).
// Ports:
//   clk, rst                    : clock, async active-high reset
//   reqN_valid / reqN_ready     : request handshake, N = 0,1
//   reqN_src1, reqN_src2        : operands
//   reqN_ctrl, reqN_arith       : ALU op code, arithmetic shift select
//   rsp_valid / rsp_ready       : response handshake
//   rsp_id                      : requester that issued the buffered result
//   rsp_data, rsp_zero          : registered ALU result and zero flag
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [XLEN-1:0]     req0_src1,
  input  logic [XLEN-1:0]     req0_src2,
  input  logic [ALU_OP_W-1:0] req0_ctrl,
  input  logic                req0_arith,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [XLEN-1:0]     req1_src1,
  input  logic [XLEN-1:0]     req1_src2,
  input  logic [ALU_OP_W-1:0] req1_ctrl,
  input  logic                req1_arith,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [XLEN-1:0]     rsp_data,
  output logic                rsp_zero
);

  rsp_state_e state_p1, state_d;
  logic       prio_p1;
  logic       vld_p1;
  logic       id_p1;
  logic [XLEN-1:0] data_p1;
  logic       zero_p1;

  logic       grant_vld, grant_id, free, accept;

  logic [XLEN-1:0]     src1_p0, src2_p0;
  logic [ALU_OP_W-1:0] ctrl_p0;
  logic                arith_p0;
  logic [XLEN-1:0]     result_p0;
  logic                zero_p0;

  // ---- stage p0: arbitration, operand mux, ALU ----
  always_comb begin
    grant_vld  = req0_valid | req1_valid;
    grant_id   = 1'b0;
    if (req0_valid && req1_valid) grant_id = prio_p1;
    else if (req1_valid)          grant_id = 1'b1;

    // A buffer being drained this cycle can take a new result at the same edge.
    free       = (state_p1 == EMPTY) | rsp_ready;
    accept     = free & grant_vld;
    req0_ready = accept & ~grant_id;
    req1_ready = accept &  grant_id;

    state_d = state_p1;
    if (accept)         state_d = FULL;
    else if (rsp_ready) state_d = EMPTY;
  end

  // With no grant, grant_id is 0 so the ALU sees requester 0; nothing is captured.
  assign src1_p0  = grant_id ? req1_src1  : req0_src1;
  assign src2_p0  = grant_id ? req1_src2  : req0_src2;
  assign ctrl_p0  = grant_id ? req1_ctrl  : req0_ctrl;
  assign arith_p0 = grant_id ? req1_arith : req0_arith;

  alu #(.XLEN(XLEN)) u_alu (
    .src1   (src1_p0),
    .src2   (src2_p0),
    .ctrl   (ctrl_p0),
    .arith  (arith_p0),
    .result (result_p0),
    .zero   (zero_p0)
  );

  // ---- stage p1: response buffer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1 <= EMPTY;
      prio_p1  <= 1'b0;
      id_p1    <= 1'b0;
      data_p1  <= '0;
      zero_p1  <= 1'b0;
    end else begin
      state_p1 <= state_d;
      if (accept) begin
        prio_p1 <= ~grant_id;
        id_p1   <= grant_id;
        data_p1 <= result_p0;
        zero_p1 <= zero_p0;
      end
    end
  end

  assign vld_p1    = (state_p1 == FULL);
  assign rsp_valid = vld_p1;
  assign rsp_id    = id_p1;
  assign rsp_data  = data_p1;
  assign rsp_zero  = zero_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_arith;
  logic [31:0] req0_src1, req0_src2;
  logic [2:0]  req0_ctrl;
  logic        req1_valid, req1_ready, req1_arith;
  logic [31:0] req1_src1, req1_src2;
  logic [2:0]  req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .req0_ctrl(req0_ctrl), .req0_arith(req0_arith),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .req1_ctrl(req1_ctrl), .req1_arith(req1_arith),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  task automatic set_req0(input logic v, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic ar);
    req0_valid = v; req0_ctrl = c; req0_src1 = a; req0_src2 = b; req0_arith = ar;
  endtask

  task automatic set_req1(input logic v, input logic [2:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic ar);
    req1_valid = v; req1_ctrl = c; req1_src1 = a; req1_src2 = b; req1_arith = ar;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_req0(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0);
    set_req1(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_zero !== 1'b0 || rsp_id !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h zero=%b id=%b, want 0/00000000/0/0",
               rsp_valid, rsp_data, rsp_zero, rsp_id);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_grant: got r0=%b r1=%b, want 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12) begin
      failures++;
      $display("FAIL reset_first_rsp: got valid=%b id=%b data=%h, want 1/0/0000000c",
               rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    set_req0(1'b0, ALU_ADD, 0, 0, 1'b0);
    set_req1(1'b0, ALU_ADD, 0, 0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_drain: got valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req0(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0);
    set_req1(1'b0, ALU_ADD, 0, 0, 1'b0);
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_ready: got r0=%b r1=%b, want 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL single_rsp: got valid=%b data=%h id=%b zero=%b, want 1/0000000c/0/0",
               rsp_valid, rsp_data, rsp_id, rsp_zero);
    end
    @(negedge clk);
    set_req0(1'b0, ALU_ADD, 0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_alternation();
    logic [31:0] exp_data;
    pulse_reset();
    set_req0(1'b1, ALU_SUB, 32'd3, 32'd3, 1'b0);
    set_req1(1'b1, ALU_SR, 32'h8000_0000, 32'd4, 1'b1);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        failures++;
        $display("FAIL alt_ready[%0d]: got r0=%b r1=%b", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      exp_data = (i % 2 == 1) ? 32'hF800_0000 : 32'd0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== exp_data ||
          rsp_zero !== (i % 2 == 0)) begin
        failures++;
        $display("FAIL alt_rsp[%0d]: got valid=%b id=%b data=%h zero=%b, want id=%0d data=%h",
                 i, rsp_valid, rsp_id, rsp_data, rsp_zero, i % 2, exp_data);
      end
      @(negedge clk);
    end
  endtask

  // Entered at a negedge with the buffer FULL holding req1's 0xF8000000 and prio=0.
  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req0(1'b1, ALU_ADD, 32'd5, 32'd7, 1'b0);
    set_req1(1'b1, ALU_ADD, 32'd1, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got r0=%b r1=%b, want 0/0", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'hF800_0000 || rsp_zero !== 1'b0) begin
        failures++;
        $display("FAIL stall_rsp[%0d]: got valid=%b id=%b data=%h zero=%b, want 1/1/f8000000/0",
                 i, rsp_valid, rsp_id, rsp_data, rsp_zero);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL release_ready: got r0=%b r1=%b, want 1/0", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'd12) begin
      failures++;
      $display("FAIL release_rsp: got valid=%b id=%b data=%h, want 1/0/0000000c",
               rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    set_req0(1'b0, ALU_ADD, 0, 0, 1'b0);
    set_req1(1'b0, ALU_ADD, 0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_alu_boundary();
    logic [2:0]  ops   [3] = '{ALU_SLT, ALU_SL, ALU_SR};
    logic [31:0] a     [3] = '{32'hFFFF_FFFF, 32'd1, 32'h8000_0000};
    logic [31:0] b     [3] = '{32'd1, 32'd33, 32'd31};
    logic [31:0] exp_r [3] = '{32'd1, 32'd2, 32'd1};
    @(negedge clk);
    rsp_ready = 1'b1;
    set_req0(1'b0, ALU_ADD, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_req1(1'b1, ops[i], a[i], b[i], 1'b0);
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== exp_r[i]) begin
        failures++;
        $display("FAIL alu_boundary[%0d]: got valid=%b id=%b data=%h, want 1/1/%h",
                 i, rsp_valid, rsp_id, rsp_data, exp_r[i]);
      end
      @(negedge clk);
    end
    set_req1(1'b0, ALU_ADD, 0, 0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    set_req0(1'b1, ALU_ADD, 32'd20, 32'd22, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    set_req0(1'b0, ALU_ADD, 0, 0, 1'b0);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd42) begin
      failures++;
      $display("FAIL midstall_full: got valid=%b data=%h, want 1/0000002a", rsp_valid, rsp_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
      failures++;
      $display("FAIL midstall_async: got valid=%b data=%h id=%b zero=%b, want 0/00000000/0/0",
               rsp_valid, rsp_data, rsp_id, rsp_zero);
    end
    rst = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data === 32'd42) begin
        failures++;
        $display("FAIL midstall_after[%0d]: got valid=%b data=%h, want valid 0", i, rsp_valid, rsp_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternation();
    test_backpressure();
    test_alu_boundary();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 32-bit integer ALU between two requesters, for example the main execute path and an address-generation or multi-cycle helper unit. Requests use a valid/ready handshake and are granted round-robin. The granted operation runs through one `alu` instance, and its result is registered into a single-entry response buffer. The buffer drains through its own valid/ready handshake, so the block is a one-deep, latency-1, throughput-1 shared ALU service.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported, matching `alu`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 operation accepted this cycle when high with `req0_valid`.
- `req0_src1`, `req0_src2`  in  XLEN  operands.
- `req0_ctrl`  in  3  ALU op code (`ALU_*` from `defs.sv`).
- `req0_arith`  in  1  arithmetic right shift select for `ALU_SR`.
- `req1_valid`, `req1_ready`, `req1_src1`, `req1_src2`, `req1_ctrl`, `req1_arith`: same as requester 0.
- `rsp_valid`  out  1  response buffer holds a result.
- `rsp_ready`  in  1  consumer takes the response this cycle.
- `rsp_id`  out  1  requester that issued the buffered result.
- `rsp_data`  out  XLEN  registered ALU result.
- `rsp_zero`  out  1  registered ALU zero flag (result == 0).

## Operation
- **States.**
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
- **Free condition.** `free = (state==EMPTY) | rsp_ready`. A FULL buffer being drained accepts a new operation in the same cycle.
- **Priority pointer.** `prio` is 1 bit, reset value 0.
- **Grant.**
  - If both requests are valid, grant `prio`.
  - If one is valid, grant that one.
  - If neither is valid, no grant.
- **Ready.** `reqN_ready = free & grant==N`.
  - At most one ready is high per cycle.
  - The ready of a losing requester depends combinationally on the other requester's valid and on `rsp_ready`; both are permitted.
- **Accept** (granted valid & ready):
  - The granted operands, ctrl and arith drive the `alu` sub-module combinationally.
  - On the clock edge, `rsp_data`, `rsp_zero` and `rsp_id` capture the result.
  - State becomes FULL.
  - `prio` becomes the non-granted index.
- **Drain only** (FULL, `rsp_ready`=1, no accept): state becomes EMPTY and the `rsp_*` payload holds its last value.
- **Stall** (FULL, `rsp_ready`=0): all `rsp_*` outputs are stable, both readies are 0 and `prio` is unchanged.
- **Idle** (EMPTY, no valid): no state change.
- **ALU mux.** When nothing is granted, the ALU inputs select requester 0. The result is not captured.
- **Arithmetic.** Defined entirely by `alu`:
  - shift amount is `src2[4:0]`;
  - `ALU_SLT` returns bit 31 of `src1-src2`, zero-extended;
  - `ALU_SR` with `arith`=1 is sign-filling.
- **Reset.** Asserting `rst` at any time, including FULL mid-stall, immediately forces:
  - `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_zero`=0;
  - `prio`=0, state EMPTY.
  
  The buffered result is discarded. Readies follow combinationally from the reset state.

## Timing
- Latency: accept at edge N gives `rsp_valid`=1 and valid payload after edge N.
- Throughput: one operation per cycle while `rsp_ready` is held 1.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1… Either requester waits at most one accepted operation of the other.
- Requesters must hold payload stable while valid and not ready. The block never depends on this for correctness of an accepted cycle.
- Combinational paths:
  - `reqN_*` → ALU → `rsp_*` D-inputs only.
  - `rsp_ready`/`reqM_valid` → `reqN_ready`.
  - No combinational path from any request input to `rsp_*` outputs.

## Structure
- `defs.sv` holds the `ALU_*` op-code constants and a 3-bit op-code width constant. The block adds no new op codes.
- `defs.sv` also holds the state encoding constants (EMPTY=0, FULL=1).
- Sub-module: one instance of the existing `alu`, named `u_alu`. Its `zero` output feeds `rsp_zero`.
- Arbitration, operand mux and response register live in `alu_arbiter`; no further sub-modules.

## Test plan
- **Reset.** Assert `rst` with both requests valid → while asserted: `rsp_valid`=0, `rsp_data`=0, `rsp_zero`=0, `rsp_id`=0; first grant after deassert goes to requester 0.
- **Single op.** Requester 0 only, `ALU_ADD` 5+7, `rsp_ready`=1 → `req0_ready`=1; next cycle `rsp_valid`=1, `rsp_data`=12, `rsp_id`=0, `rsp_zero`=0.
- **Alternation.** Both valid for 4 cycles, `rsp_ready`=1:
  - req0 `ALU_SUB` 3−3;
  - req1 `ALU_SR`, arith=1, 0x80000000 by 4.
  
  → responses ids 0,1,0,1; data 0 (`rsp_zero`=1), 0xF8000000, 0, 0xF8000000.
- **Backpressure.** Result buffered, `rsp_ready`=0 for 3 cycles with both valid → both readies 0 and `rsp_*` unchanged. Raising `rsp_ready` → same-cycle accept of the `prio` requester and new data the next cycle.
- **ALU boundary.**
  - `ALU_SLT` 0xFFFFFFFF vs 1 → 1.
  - `ALU_SL` 1 by 33 → 2.
  - `ALU_SR` arith=0 of 0x80000000 by 31 → 1.
- **Reset mid-stall.** FULL with `rsp_ready`=0, pulse `rst` between edges → `rsp_valid` drops without a clock edge; after release the old result is never presented.
